// File: rtl/prm_chk_pkg.sv
// Shared defaults and FSM encoding for the edge-query sequencer and its packer.
package prm_chk_pkg;

    localparam int unsigned IDX_W_DEF  = 15;
    localparam int unsigned OBS_N_DEF  = 8;
    localparam int unsigned WORD_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/prm_word_packer.sv
// Assembles blocked-edge bits into words and holds one finished word for a
// valid/ready consumer; raises o_stall when a finished word cannot be handed off.
module prm_word_packer #(
    parameter int unsigned IDX_W  = prm_chk_pkg::IDX_W_DEF,
    parameter int unsigned WORD_W = prm_chk_pkg::WORD_W_DEF,
    parameter int unsigned CNT_W  = prm_chk_pkg::CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_capture,
    input  logic              i_bit,
    input  logic              i_last,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic              i_ready,
    output logic              o_stall,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_data,
    output logic [IDX_W-1:0]  o_base,
    output logic [CNT_W-1:0]  o_cnt
);

    logic [WORD_W-1:0] r_asm;
    logic [CNT_W-1:0]  r_n;
    logic [IDX_W-1:0]  r_asm_base;
    logic              r_valid;
    logic [WORD_W-1:0] r_data;
    logic [IDX_W-1:0]  r_base;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_full;
    logic              w_can_load;
    logic              w_take;
    logic [WORD_W-1:0] w_word;
    logic [IDX_W-1:0]  w_base;

    assign w_full     = (r_n == CNT_W'(WORD_W - 1)) || i_last;
    assign w_can_load = !r_valid || i_ready;
    assign o_stall    = i_capture && w_full && !w_can_load;
    assign w_take     = i_capture && !o_stall;
    assign w_word     = r_asm | (WORD_W'(i_bit) << r_n);
    // A one-bit word takes its base from the edge being captured right now.
    assign w_base     = (r_n == '0) ? i_idx : r_asm_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_asm      <= '0;
            r_n        <= '0;
            r_asm_base <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_base     <= '0;
            r_cnt      <= '0;
        end else begin
            if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
            if (w_take) begin
                if (w_full) begin
                    r_valid <= 1'b1;
                    r_data  <= w_word;
                    r_base  <= w_base;
                    r_cnt   <= r_n + CNT_W'(1);
                    r_asm   <= '0;
                    r_n     <= '0;
                end else begin
                    r_asm <= w_word;
                    r_n   <= r_n + CNT_W'(1);
                    if (r_n == '0) begin
                        r_asm_base <= i_idx;
                    end
                end
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_base  = r_base;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/prm_edge_query_seq.sv
// Issues edge-index queries to the combinational obstacle checkers, ORs the
// enabled obstacle hits per edge and streams packed result words.
module prm_edge_query_seq #(
    parameter int unsigned IDX_W  = prm_chk_pkg::IDX_W_DEF,
    parameter int unsigned OBS_N  = prm_chk_pkg::OBS_N_DEF,
    parameter int unsigned WORD_W = prm_chk_pkg::WORD_W_DEF,
    parameter int unsigned CNT_W  = prm_chk_pkg::CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  idx_first,
    input  logic [IDX_W-1:0]  idx_last,
    input  logic [OBS_N-1:0]  obs_en,
    output logic [IDX_W-1:0]  qry_idx,
    input  logic [OBS_N-1:0]  chk_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_base,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              busy,
    output logic              done
);

    import prm_chk_pkg::*;

    seq_state_t       r_state;
    logic [IDX_W:0]   r_idx;
    logic [IDX_W-1:0] r_last;
    logic [OBS_N-1:0] r_obs_en;
    logic             r_busy;
    logic             r_done;

    logic             w_capture;
    logic             w_bit;
    logic             w_last;
    logic             w_stall;

    assign w_capture = (r_state == ST_RUN);
    assign w_bit     = |(chk_mask & r_obs_en);
    // Extra counter bit keeps idx_last = all-ones from aliasing index 0.
    assign w_last    = (r_idx == {1'b0, r_last});

    prm_word_packer #(
        .IDX_W  (IDX_W),
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .i_capture (w_capture),
        .i_bit     (w_bit),
        .i_last    (w_last),
        .i_idx     (r_idx[IDX_W-1:0]),
        .i_ready   (out_ready),
        .o_stall   (w_stall),
        .o_valid   (out_valid),
        .o_data    (out_data),
        .o_base    (out_base),
        .o_cnt     (out_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_last   <= '0;
            r_obs_en <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FIN);
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx    <= {1'b0, idx_first};
                        r_last   <= idx_last;
                        r_obs_en <= obs_en;
                        if (idx_last >= idx_first) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_FIN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!w_stall) begin
                        if (w_last) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!out_valid || out_ready) begin
                        r_state <= ST_FIN;
                        r_busy  <= 1'b0;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign qry_idx = r_idx[IDX_W-1:0];
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_prm_edge_query_seq.sv
// Directed bench for prm_edge_query_seq with a small behavioural checker bank.
module tb_prm_edge_query_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [14:0] idx_first;
    logic [14:0] idx_last;
    logic [7:0]  obs_en;
    logic [14:0] qry_idx;
    logic [7:0]  chk_mask;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [14:0] out_base;
    logic [5:0]  out_cnt;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    logic [31:0] w_data [8];
    logic [14:0] w_base [8];
    logic [5:0]  w_cnt  [8];
    int nw, cyc, first_valid, done_cyc, zero_busy, run_like, hold_bad, busy_seen;
    logic [14:0] qry_at70, qry_at80;
    int cnt_v, cnt_d;

    prm_edge_query_seq #(
        .IDX_W  (15),
        .OBS_N  (8),
        .WORD_W (32),
        .CNT_W  (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .idx_first (idx_first),
        .idx_last  (idx_last),
        .obs_en    (obs_en),
        .qry_idx   (qry_idx),
        .chk_mask  (chk_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_base  (out_base),
        .out_cnt   (out_cnt),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Mode 0: obstacle 0 hits every third edge, obstacles 1..7 always hit.
    // Mode 1: only obstacle 2 hits, on every edge.
    always_comb begin
        if (mode == 0) chk_mask = {7'h7F, ((qry_idx % 15'd3) == 15'd0)};
        else           chk_mask = 8'h04;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [14:0] f, input logic [14:0] l, input logic [7:0] oe,
                       input int lo, input int hi, input int inj, input int budget);
        logic        prev_v, prev_r;
        logic [52:0] prev_w;
        nw = 0; first_valid = -1; done_cyc = -1; zero_busy = 0;
        run_like = 0; hold_bad = 0; busy_seen = 0;
        qry_at70 = '0; qry_at80 = '0;
        idx_first = f; idx_last = l; obs_en = oe; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        prev_v = 1'b0; prev_r = 1'b1; prev_w = '0;
        while (cyc < budget && done_cyc < 0) begin
            out_ready = !(cyc >= lo && cyc <= hi);
            if (cyc == inj) begin
                start = 1'b1; idx_first = 15'd0; idx_last = 15'd3; obs_en = 8'h00;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_seen++;
            if (busy && qry_idx == 15'd0 && f != 15'd0) zero_busy++;
            if (busy && !out_valid) run_like++;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && prev_v && !prev_r && {out_data, out_base, out_cnt} !== prev_w) hold_bad++;
            if (cyc == 70) qry_at70 = qry_idx;
            if (cyc == 80) qry_at80 = qry_idx;
            if (done) done_cyc = cyc;
            if (out_valid && out_ready && nw < 8) begin
                w_data[nw] = out_data; w_base[nw] = out_base; w_cnt[nw] = out_cnt;
                nw++;
            end
            prev_v = out_valid; prev_r = out_ready; prev_w = {out_data, out_base, out_cnt};
            step();
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; idx_first = '0; idx_last = '0; obs_en = '0; out_ready = 1'b1;
        step(); step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_done",  64'(done),      64'd0);
        check("rst_qry",   64'(qry_idx),   64'd0);
        check("rst_data",  64'(out_data),  64'd0);
        check("rst_cnt",   64'(out_cnt),   64'd0);
        check("rst_base",  64'(out_base),  64'd0);
        rst = 1'b0;
        step();

        // Full 32-edge word, latency reference
        mode = 0;
        run(15'd0, 15'd31, 8'h01, -1, -2, -1, 200);
        check("t1_nw",    64'(nw),          64'd1);
        check("t1_data",  64'(w_data[0]),   64'h49249249);
        check("t1_base",  64'(w_base[0]),   64'd0);
        check("t1_cnt",   64'(w_cnt[0]),    64'd32);
        check("t1_valid", 64'(first_valid), 64'd33);
        check("t1_done",  64'(done_cyc),    64'd35);
        step(); step();

        // 40 edges split across two words, stray start mid-run
        mode = 1;
        run(15'd100, 15'd139, 8'h04, -1, -2, 10, 200);
        check("t2_nw",    64'(nw),        64'd2);
        check("t2_d0",    64'(w_data[0]), 64'hFFFFFFFF);
        check("t2_b0",    64'(w_base[0]), 64'd100);
        check("t2_c0",    64'(w_cnt[0]),  64'd32);
        check("t2_d1",    64'(w_data[1]), 64'h000000FF);
        check("t2_b1",    64'(w_base[1]), 64'd132);
        check("t2_c1",    64'(w_cnt[1]),  64'd8);
        check("t2_done",  64'(done_cyc),  64'd43);
        step(); step();

        // Consumer back-pressure over cycles 30..80
        mode = 0;
        run(15'd0, 15'd95, 8'h01, 30, 80, -1, 400);
        check("t3_nw",    64'(nw),        64'd3);
        check("t3_d0",    64'(w_data[0]), 64'h49249249);
        check("t3_d1",    64'(w_data[1]), 64'h92492492);
        check("t3_d2",    64'(w_data[2]), 64'h24924924);
        check("t3_b1",    64'(w_base[1]), 64'd32);
        check("t3_b2",    64'(w_base[2]), 64'd64);
        check("t3_c2",    64'(w_cnt[2]),  64'd32);
        check("t3_hold",  64'(hold_bad),  64'd0);
        check("t3_q70",   64'(qry_at70),  64'd63);
        check("t3_q80",   64'(qry_at80),  64'd63);
        check("t3_done",  64'(done_cyc),  64'd116);
        step(); step();

        // Top-of-range indices
        mode = 1;
        run(15'h7FF0, 15'h7FFF, 8'h04, -1, -2, -1, 200);
        check("t4_nw",    64'(nw),        64'd1);
        check("t4_data",  64'(w_data[0]), 64'h0000FFFF);
        check("t4_base",  64'(w_base[0]), 64'h7FF0);
        check("t4_cnt",   64'(w_cnt[0]),  64'd16);
        check("t4_qrys",  64'(run_like),  64'd16);
        check("t4_wrap",  64'(zero_busy), 64'd0);
        check("t4_done",  64'(done_cyc),  64'd19);
        step(); step();

        // Empty range
        run(15'd5, 15'd4, 8'hFF, -1, -2, -1, 50);
        check("t5_nw",    64'(nw),          64'd0);
        check("t5_valid", 64'(first_valid), -64'sd1);
        check("t5_busy",  64'(busy_seen),   64'd0);
        check("t5_done",  64'(done_cyc),    64'd2);
        step(); step();

        // Reset in the middle of a run
        mode = 0;
        idx_first = 15'd0; idx_last = 15'd63; obs_en = 8'h01; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i < 20; i++) step();
        check("t6_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_valid", 64'(out_valid), 64'd0);
        check("t6_busy",  64'(busy),      64'd0);
        check("t6_qry",   64'(qry_idx),   64'd0);
        check("t6_cnt",   64'(out_cnt),   64'd0);
        cnt_v = 0; cnt_d = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) cnt_v++;
            if (done) cnt_d++;
            step();
        end
        check("t6_novalid", 64'(cnt_v), 64'd0);
        check("t6_nodone",  64'(cnt_d), 64'd0);
        run(15'd0, 15'd31, 8'h01, -1, -2, -1, 200);
        check("t6_nw",    64'(nw),        64'd1);
        check("t6_data",  64'(w_data[0]), 64'h49249249);
        check("t6_done",  64'(done_cyc),  64'd35);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
